// File: rtl/cfu_simd_mac_ctrl_pkg.sv
// cfu_simd_mac_ctrl_pkg: op codes, funct7 fields, FSM states and saturating accumulate helper
package cfu_simd_mac_ctrl_pkg;
    localparam logic [2:0] F3_ALU       = 3'd0;
    localparam logic [2:0] F3_MAC       = 3'd1;
    localparam logic [2:0] F3_MAC_CLEAR = 3'd2;
    localparam logic [2:0] F3_SET_OFF   = 3'd3;
    localparam logic [2:0] F3_ACC_READ  = 3'd4;
    localparam logic [2:0] F3_ACC_WRITE = 3'd5;
    localparam logic [2:0] F3_STATUS    = 3'd6;
    localparam logic [6:0] ALU_ADD = 7'd0;
    localparam logic [6:0] ALU_SUB = 7'd1;
    localparam logic [6:0] ALU_MUL = 7'd2;
    localparam int F7_READ_CLEAR   = 6;
    localparam int F7_STATUS_CLEAR = 0;
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
    // Returns {overflow, result}; result clamps on signed overflow when sat is set.
    function automatic logic [32:0] acc_add(input logic [31:0] acc, input logic [31:0] sum, input logic sat);
        logic [31:0] s;
        logic o;
        s = acc + sum;
        o = (acc[31] == sum[31]) && (s[31] != acc[31]);
        return {o, (o && sat) ? (acc[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : s};
    endfunction
endpackage

// File: rtl/cfu_simd_mac_ctrl_dot_pipe.sv
// cfu_simd_mac_ctrl_dot_pipe: lane-parallel int8 dot product (a_i+offset)*b_i with PIPE_STAGES register stages
// Ports: clk, reset (sync, active-high); in_valid/a/b/offset in; out_valid/sum out, delayed PIPE_STAGES cycles.
module cfu_simd_mac_ctrl_dot_pipe #(
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] offset,
    output logic        out_valid,
    output logic [31:0] sum
);
    logic [31:0] sum_c;
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < LANES; i++)
            sum_c = sum_c + (32'(signed'(a[8*i +: 8])) + offset) * 32'(signed'(b[8*i +: 8]));
    end
    if (PIPE_STAGES == 0) begin : g_comb
        assign sum       = sum_c;
        assign out_valid = in_valid;
    end else begin : g_pipe
        logic [31:0] sum_q [PIPE_STAGES];
        logic [PIPE_STAGES-1:0] v_q;
        always_ff @(posedge clk) begin
            v_q <= reset ? '0 : PIPE_STAGES'({v_q, in_valid});
            sum_q[0] <= sum_c;
            for (int s = 1; s < PIPE_STAGES; s++) sum_q[s] <= sum_q[s-1];
        end
        assign sum       = sum_q[PIPE_STAGES-1];
        assign out_valid = v_q[PIPE_STAGES-1];
    end
endmodule

// File: rtl/cfu_simd_mac_ctrl.sv
// cfu_simd_mac_ctrl: CFU core with SIMD int8 dot-product MAC, accumulator bank, ALU ops and activation offset
// Ports: clk, reset (sync, active-high); cmd_valid/cmd_ready + function_id, inputs_0, inputs_1 in;
//        rsp_valid/rsp_ready + registered rsp_payload_outputs_0 out.
module cfu_simd_mac_ctrl
    import cfu_simd_mac_ctrl_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int NUM_ACC     = 4,
    parameter int PIPE_STAGES = 2,
    parameter bit SATURATE    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0
);
    localparam int IW = NUM_ACC > 1 ? $clog2(NUM_ACC) : 1;
    state_t state, state_n;
    logic [31:0] acc [NUM_ACC];
    logic [31:0] offset, res, sum;
    logic [32:0] add;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [IW-1:0] idx, idx_q, idx_m;
    logic ovf, accept, sum_valid, acc_we;
    assign f3     = cmd_payload_function_id[2:0];
    assign f7     = cmd_payload_function_id[9:3];
    assign accept = cmd_valid && cmd_ready;
    // Masking with NUM_ACC-1 drops the unused index bits, also for a single accumulator.
    assign idx    = IW'(f7 & 7'(NUM_ACC - 1));
    // Without pipe stages the MAC retires on the accept edge, before idx_q is loaded.
    assign idx_m  = PIPE_STAGES == 0 ? idx : idx_q;
    assign add    = acc_add(acc[idx_m], sum, SATURATE);
    assign acc_we = accept && (f3 == F3_MAC_CLEAR || f3 == F3_ACC_WRITE ||
                               (f3 == F3_ACC_READ && f7[F7_READ_CLEAR]));
    cfu_simd_mac_ctrl_dot_pipe #(.LANES(LANES), .PIPE_STAGES(PIPE_STAGES)) u_dot (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (accept && f3 == F3_MAC),
        .a         (cmd_payload_inputs_0),
        .b         (cmd_payload_inputs_1),
        .offset    (offset),
        .out_valid (sum_valid),
        .sum       (sum)
    );
    always_comb begin
        res = f3 == F3_ALU ? (f7 == ALU_ADD ? cmd_payload_inputs_0 + cmd_payload_inputs_1 :
                              f7 == ALU_SUB ? cmd_payload_inputs_0 - cmd_payload_inputs_1 :
                              f7 == ALU_MUL ? cmd_payload_inputs_0 * cmd_payload_inputs_1 : '0) :
              f3 == F3_SET_OFF ? offset :
              (f3 == F3_ACC_READ || f3 == F3_ACC_WRITE) ? acc[idx] :
              f3 == F3_STATUS ? {31'b0, ovf} : '0;
    end
    always_ff @(posedge clk) state <= reset ? S_IDLE : state_n;
    always_comb begin
        state_n = state == S_IDLE ? (accept ? ((f3 == F3_MAC && PIPE_STAGES > 0) ? S_BUSY : S_RESP) : S_IDLE) :
                  state == S_BUSY ? (sum_valid ? S_RESP : S_BUSY) :
                  state == S_RESP ? (rsp_ready ? S_IDLE : S_RESP) : S_IDLE;
    end
    always_comb begin
        cmd_ready = state == S_IDLE;
        rsp_valid = state == S_RESP;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
            offset                <= '0;
            ovf                   <= 1'b0;
            idx_q                 <= '0;
            rsp_payload_outputs_0 <= '0;
        end else begin
            if (accept) idx_q <= idx;
            if (accept && f3 != F3_MAC) rsp_payload_outputs_0 <= res;
            if (acc_we) acc[idx] <= f3 == F3_ACC_WRITE ? cmd_payload_inputs_0 : '0;
            if (accept && f3 == F3_SET_OFF) offset <= cmd_payload_inputs_0;
            if (accept && f3 == F3_STATUS && f7[F7_STATUS_CLEAR]) ovf <= 1'b0;
            if (sum_valid) begin
                acc[idx_m]            <= add[31:0];
                rsp_payload_outputs_0 <= add[31:0];
                ovf                   <= ovf | add[32];
            end
        end
    end
endmodule

// File: tb/tb_cfu_simd_mac_ctrl.sv
// tb_cfu_simd_mac_ctrl: table-driven directed test of cfu_simd_mac_ctrl plus backpressure and reset sequences
module tb_cfu_simd_mac_ctrl;
    logic clk = 0, reset = 1, cmd_valid = 0, rsp_ready = 1;
    logic cmd_ready, rsp_valid;
    logic [9:0] fid = '0;
    logic [31:0] in0 = '0, in1 = '0, rsp_data;
    int total = 0, passed = 0;
    typedef struct {
        logic [9:0]  f;
        logic [31:0] a, b;
        int          lat;
        logic [31:0] exp;
        string       nm;
    } vec_t;
    vec_t v [$];
    always #5 clk = ~clk;
    cfu_simd_mac_ctrl dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (fid),
        .cmd_payload_inputs_0    (in0),
        .cmd_payload_inputs_1    (in1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_data)
    );
    function automatic logic [9:0] fn(input int f7, input int f3);
        return {7'(f7), 3'(f3)};
    endfunction
    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endfunction
    function automatic void add_v(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                                  input int lat, input logic [31:0] exp, input string nm);
        vec_t t;
        t.f = f; t.a = a; t.b = b; t.lat = lat; t.exp = exp; t.nm = nm;
        v.push_back(t);
    endfunction
    // Called at a negedge; returns at a negedge.
    task automatic xact(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int lat_exp, input logic [31:0] exp, input string nm);
        int lat;
        check({nm, "_ready"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1; fid = f; in0 = a; in1 = b;
        @(negedge clk);
        cmd_valid = 0; fid = 10'($urandom); in0 = $urandom; in1 = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({nm, "_lat"}, 64'(lat), 64'(lat_exp));
        check({nm, "_data"}, 64'(rsp_data), 64'(exp));
        if (rsp_ready) begin
            @(negedge clk);
            check({nm, "_idle"}, 64'({rsp_valid, cmd_ready}), 64'b01);
        end
    endtask
    initial begin
        add_v(fn(0, 3), 32'd128, 0, 1, 32'd0, "setoff1");
        add_v(fn(0, 3), 32'd128, 0, 1, 32'd128, "setoff2");
        add_v(fn(0, 1), 32'h01FF0080, 32'h02030405, 3, 32'd1151, "mac0a");
        add_v(fn(0, 1), 32'h01FF0080, 32'h02030405, 3, 32'd2302, "mac0b");
        add_v(fn(0, 3), 32'd0, 0, 1, 32'd128, "setoff0");
        add_v(fn(1, 1), 32'd2, 32'd3, 3, 32'd6, "mac1");
        add_v(fn(0, 4), 0, 0, 1, 32'd2302, "rd0");
        add_v(fn(7'h41, 4), 0, 0, 1, 32'd6, "rd1clr");
        add_v(fn(1, 4), 0, 0, 1, 32'd0, "rd1");
        add_v(fn(2, 5), 32'h7FFFFF00, 0, 1, 32'd0, "wr2");
        add_v(fn(2, 1), 32'h7F7F7F7F, 32'h7F7F7F7F, 3, 32'h7FFFFFFF, "macsat_hi");
        add_v(fn(1, 6), 0, 0, 1, 32'd1, "stat_clr");
        add_v(fn(0, 6), 0, 0, 1, 32'd0, "stat0");
        add_v(fn(0, 0), 32'd5, 32'd7, 1, 32'd12, "add");
        add_v(fn(1, 0), 32'd5, 32'd7, 1, 32'hFFFFFFFE, "sub");
        add_v(fn(2, 0), 32'h10000, 32'h10001, 1, 32'h00010000, "mul");
        add_v(fn(3, 0), 32'd5, 32'd7, 1, 32'd0, "alu_bad");
        add_v(fn(3, 5), 32'h80000010, 0, 1, 32'd0, "wr3");
        add_v(fn(3, 1), 32'h80808080, 32'h7F7F7F7F, 3, 32'h80000000, "macsat_lo");
        add_v(fn(0, 6), 0, 0, 1, 32'd1, "stat_keep");
        add_v(fn(1, 6), 0, 0, 1, 32'd1, "stat_clr2");
        add_v(fn(0, 6), 0, 0, 1, 32'd0, "stat_after");
        add_v(fn(5, 5), 32'h55, 0, 1, 32'd0, "wr_alias");
        add_v(fn(1, 4), 0, 0, 1, 32'h55, "rd_alias");
        add_v(fn(0, 2), 0, 0, 1, 32'd0, "clr0");
        add_v(fn(0, 4), 0, 0, 1, 32'd0, "rd0_clr");
        add_v(fn(0, 3), 32'hFFFFFFFF, 0, 1, 32'd0, "setoff_neg");
        add_v(fn(0, 1), 32'd3, 32'd2, 3, 32'd4, "mac_negoff");
        add_v(fn(0, 3), 32'd0, 0, 1, 32'hFFFFFFFF, "setoff_ret");
        repeat (2) @(negedge clk);
        check("rst_state", 64'({rsp_valid, cmd_ready, rsp_data}), 64'({1'b0, 1'b1, 32'd0}));
        reset = 0;
        @(negedge clk);
        foreach (v[i]) xact(v[i].f, v[i].a, v[i].b, v[i].lat, v[i].exp, v[i].nm);
        // Backpressure: response held with rsp_ready low; a stray command must be ignored.
        rsp_ready = 0;
        xact(fn(0, 4), 0, 0, 1, 32'd4, "bp_rd");
        for (int c = 0; c < 5; c++) begin
            cmd_valid = c == 2; fid = fn(0, 3); in0 = 32'h1234;
            @(negedge clk);
            check("bp_hold", 64'({rsp_valid, cmd_ready, rsp_data}), 64'({1'b1, 1'b0, 32'd4}));
        end
        cmd_valid = 0;
        rsp_ready = 1;
        @(negedge clk);
        check("bp_release", 64'({rsp_valid, cmd_ready}), 64'b01);
        xact(fn(0, 3), 32'd0, 0, 1, 32'd0, "bp_offset");
        // Reset the cycle after a MAC accept: no response, accumulators cleared.
        cmd_valid = 1; fid = fn(0, 1); in0 = 32'd2; in1 = 32'd3;
        @(negedge clk);
        cmd_valid = 0;
        reset = 1;
        @(negedge clk);
        reset = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rst_norsp", 64'({rsp_valid, cmd_ready}), 64'b01);
        end
        xact(fn(0, 4), 0, 0, 1, 32'd0, "rst_rd0");
        xact(fn(0, 5), 32'h99, 0, 1, 32'd0, "wr0");
        xact(fn(0, 7), 32'h77, 32'h77, 1, 32'd0, "f3_7");
        xact(fn(0, 4), 0, 0, 1, 32'h99, "rd0_after7");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
